// File: rtl/sc_pulse_seq.sv
// -----------------------------------------------------------------------------
// sc_pulse_seq -- special-command pulse sequencer
//
// Decodes a single-shot command word and produces:
//   * a calibration pulse with programmable delay D and width W
//     (IDLE -> DELAY -> PULSE -> IDLE),
//   * N_STROBE one-cycle strobes,
//   * a sticky register-write-disable flag.
//
// Ports
//   bclk             in   bunch-crossing clock (only clock)
//   rstb             in   asynchronous active-low reset
//   cmdLoad          in   one-cycle strobe qualifying cmdData
//   cmdData[31:0]    in   command word
//   calPulse         out  calibration pulse (registered)
//   strobe[N-1:0]    out  one-cycle strobes (registered)
//   regWriteDisable  out  sticky write-disable (registered)
//   calBusy          out  high while the sequencer is not IDLE (registered)
//   calReject        out  one-cycle flag: start dropped while busy (registered)
//
// Configuration macro
//   SC_WD_UNLOCK_EN  when defined, cmdData[14] clears regWriteDisable
//                    (bit 15 set has priority). When undefined, bit 14 is
//                    ignored and only reset clears the flag.
// -----------------------------------------------------------------------------
module sc_pulse_seq #(
  parameter int N_STROBE  = 2,
  parameter int DLY_W     = 5,
  parameter int WID_W     = 4,
  parameter int DEF_WIDTH = 8
) (
  input  logic                bclk,
  input  logic                rstb,
  input  logic                cmdLoad,
  input  logic [31:0]         cmdData,
  output logic                calPulse,
  output logic [N_STROBE-1:0] strobe,
  output logic                regWriteDisable,
  output logic                calBusy,
  output logic                calReject
);

  // One counter serves both the delay and the pulse phases.
  localparam int CNT_W = (DLY_W > WID_W) ? DLY_W : WID_W;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [WID_W-1:0] WID_DEF  = WID_W'(DEF_WIDTH);
  localparam logic [WID_W-1:0] WID_ZERO = WID_W'(1'b0);
  localparam logic [DLY_W-1:0] DLY_ZERO = DLY_W'(1'b0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DELAY = 2'b01,
    ST_PULSE = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WID_W-1:0]      wid_q, wid_d;
  logic                  pulse_q;
  logic                  busy_q;
  logic                  reject_q;
  logic [N_STROBE-1:0]   strobe_q;
  logic                  wd_q, wd_d;

  logic                  cmd_start_s;
  logic [DLY_W-1:0]      cmd_dly_s;
  logic [WID_W-1:0]      cmd_wid_raw_s;
  logic [WID_W-1:0]      cmd_wid_s;
  logic                  cnt_zero_s;
  logic                  seq_free_s;
  logic                  accept_s;
  logic                  reject_s;
  logic                  unused_cmd_s;

  // Command field decode.
  assign cmd_start_s   = cmdLoad & cmdData[0];
  assign cmd_dly_s     = cmdData[16 +: DLY_W];
  assign cmd_wid_raw_s = cmdData[24 +: WID_W];
  assign cmd_wid_s     = (cmd_wid_raw_s == WID_ZERO) ? WID_DEF : cmd_wid_raw_s;

  // Only some bits of the word are meaningful for a given configuration.
  assign unused_cmd_s  = ^cmdData;

  // A start is accepted in IDLE, and also on the final PULSE cycle so that
  // sequences can run back-to-back without an idle gap.
  assign cnt_zero_s = (cnt_q == CNT_ZERO);
  assign seq_free_s = (state_q == ST_IDLE) ||
                      ((state_q == ST_PULSE) && cnt_zero_s);
  assign accept_s   = cmd_start_s & seq_free_s;
  assign reject_s   = cmd_start_s & ~seq_free_s;

  // Calibration FSM next state, counter and latched width.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wid_d   = wid_q;
    if (accept_s) begin
      // Width is latched because the DELAY->PULSE reload happens long after
      // cmdData has gone away.
      wid_d = cmd_wid_s;
      if (cmd_dly_s == DLY_ZERO) begin
        state_d = ST_PULSE;
        cnt_d   = CNT_W'(cmd_wid_s) - CNT_ONE;
      end else begin
        state_d = ST_DELAY;
        cnt_d   = CNT_W'(cmd_dly_s) - CNT_ONE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
        ST_DELAY: begin
          if (cnt_zero_s) begin
            state_d = ST_PULSE;
            cnt_d   = CNT_W'(wid_q) - CNT_ONE;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (cnt_zero_s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_PULSE;
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Sticky write-disable next value; set wins over clear.
  always_comb begin
    wd_d = wd_q;
    if (cmdLoad && cmdData[15]) begin
      wd_d = 1'b1;
    end
`ifdef SC_WD_UNLOCK_EN
    else if (cmdLoad && cmdData[14]) begin
      wd_d = 1'b0;
    end
`endif
    else begin
      wd_d = wd_q;
    end
  end

  // State and registered outputs; outputs are derived from next state so
  // they change on the same edge as the state.
  always_ff @(posedge bclk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      wid_q    <= WID_ZERO;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      reject_q <= 1'b0;
      strobe_q <= {N_STROBE{1'b0}};
      wd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wid_q    <= wid_d;
      pulse_q  <= (state_d == ST_PULSE);
      busy_q   <= (state_d != ST_IDLE);
      reject_q <= reject_s;
      strobe_q <= cmdLoad ? cmdData[N_STROBE:1] : {N_STROBE{1'b0}};
      wd_q     <= wd_d;
    end
  end

  assign calPulse        = pulse_q;
  assign calBusy         = busy_q;
  assign calReject       = reject_q;
  assign strobe          = strobe_q;
  assign regWriteDisable = wd_q;

endmodule
